// File: rtl/spmm_sched.sv
// Central sequencer for the SpMM tile engine: RHS load, LHS stream, PE drain, output dump.
// Optional perf counters are built only when SPMM_SCHED_PERF_EN is defined.
module spmm_sched #(
    parameter int N        = 16,
    parameter int PE_DELAY = $clog2(N) + 1,
    localparam int CW      = $clog2(N),
    localparam int BW      = (N > 4) ? $clog2(N / 4) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rhs_start,
    input  logic          lhs_start,
    input  logic          lhs_ws,
    input  logic          lhs_os,
    input  logic          out_start,
    output logic          rhs_ready,
    output logic          lhs_ready_ns,
    output logic          lhs_ready_ws,
    output logic          lhs_ready_os,
    output logic          lhs_ready_wos,
    output logic          out_ready,
    output logic          rhs_we,
    output logic [BW-1:0] rhs_beat,
    output logic          lhs_fire,
    output logic [CW-1:0] lhs_row,
    output logic          acc_clear,
    output logic          acc_we,
    output logic [CW-1:0] acc_row,
    output logic          out_rd_en,
    output logic [BW-1:0] out_beat,
    output logic          busy,
    output logic          err,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_jobs,
    output logic [2:0]    state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE, S_RHS_LOAD, S_READY, S_LHS_RUN, S_DRAIN, S_OUT_DUMP
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(N / 4 - 1);
    localparam logic [CW-1:0] LAST_ROW  = CW'(N - 1);

    state_t        state, state_nxt, ret_state, ret_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          acc_valid, acc_valid_nxt, ws_q, ws_nxt, err_nxt;
    logic          lhs_sel_ready, out_acc, rhs_acc, lhs_acc, violation;
    logic [PE_DELAY-1:0] fire_pipe;
    logic [CW-1:0]       row_pipe [PE_DELAY];

    // Handshake: a start is taken only in a cycle where its ready (a pure function of
    // registered state) is high; out_start wins ties, a start with ready low sets err.
    assign rhs_ready     = (state == S_IDLE);
    assign lhs_ready_ns  = (state == S_READY) && !acc_valid;
    assign lhs_ready_ws  = (state == S_READY) && !acc_valid;
    assign lhs_ready_os  = (state == S_READY) && acc_valid;
    assign lhs_ready_wos = (state == S_READY) && acc_valid;
    assign out_ready     = ((state == S_IDLE) || (state == S_READY)) && acc_valid;
    assign busy          = (state != S_IDLE) && (state != S_READY);
    assign state_dbg     = state;
    assign acc_we        = fire_pipe[PE_DELAY-1];
    assign acc_row       = row_pipe[PE_DELAY-1];

    always_comb begin
        case ({lhs_ws, lhs_os})
            2'b00:   lhs_sel_ready = lhs_ready_ns;
            2'b10:   lhs_sel_ready = lhs_ready_ws;
            2'b01:   lhs_sel_ready = lhs_ready_os;
            default: lhs_sel_ready = lhs_ready_wos;
        endcase
    end

    assign out_acc   = reset && out_start && out_ready;
    assign rhs_acc   = reset && rhs_start && rhs_ready && !out_acc;
    assign lhs_acc   = reset && lhs_start && lhs_sel_ready && !out_acc;
    assign violation = (out_start && !out_ready)
                     || (rhs_start && !rhs_ready && !out_acc)
                     || (lhs_start && !lhs_sel_ready && !out_acc);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc_valid_nxt = acc_valid;
        ws_nxt        = ws_q;
        ret_nxt       = ret_state;
        err_nxt       = err || violation;
        rhs_we        = 1'b0;
        rhs_beat      = '0;
        lhs_fire      = 1'b0;
        lhs_row       = '0;
        acc_clear     = 1'b0;
        out_rd_en     = 1'b0;
        out_beat      = '0;
        if (out_acc) begin
            out_rd_en = 1'b1;
            ret_nxt   = state;
            cnt_nxt   = CW'(1);
            if (N / 4 == 1) acc_valid_nxt = 1'b0;
            else            state_nxt     = S_OUT_DUMP;
        end else if (rhs_acc) begin
            rhs_we    = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = (N / 4 == 1) ? S_READY : S_RHS_LOAD;
        end else if (lhs_acc) begin
            lhs_fire  = 1'b1;
            acc_clear = !lhs_os;
            ws_nxt    = lhs_ws;
            cnt_nxt   = CW'(1);
            state_nxt = S_LHS_RUN;
        end else begin
            case (state)
                S_RHS_LOAD: begin
                    rhs_we   = 1'b1;
                    rhs_beat = cnt[BW-1:0];
                    if (cnt == LAST_BEAT) begin
                        cnt_nxt   = '0;
                        state_nxt = S_READY;
                    end else cnt_nxt = cnt + CW'(1);
                end
                S_LHS_RUN: begin
                    lhs_fire = 1'b1;
                    lhs_row  = cnt;
                    if (cnt == LAST_ROW) begin
                        cnt_nxt   = '0;
                        state_nxt = S_DRAIN;
                    end else cnt_nxt = cnt + CW'(1);
                end
                S_DRAIN: begin
                    // The last row leaving the PE pipeline closes the job.
                    if (acc_we && acc_row == LAST_ROW) begin
                        acc_valid_nxt = 1'b1;
                        state_nxt     = ws_q ? S_READY : S_IDLE;
                    end
                end
                S_OUT_DUMP: begin
                    out_rd_en = 1'b1;
                    out_beat  = cnt[BW-1:0];
                    if (cnt == LAST_BEAT) begin
                        cnt_nxt       = '0;
                        acc_valid_nxt = 1'b0;
                        state_nxt     = ret_state;
                    end else cnt_nxt = cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            cnt       <= '0;
            acc_valid <= 1'b0;
            ws_q      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            cnt       <= cnt_nxt;
            acc_valid <= acc_valid_nxt;
            ws_q      <= ws_nxt;
            err       <= err_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_pipe <= '0;
            for (int i = 0; i < PE_DELAY; i++) row_pipe[i] <= '0;
        end else begin
            fire_pipe[0] <= lhs_fire;
            row_pipe[0]  <= lhs_row;
            for (int i = 1; i < PE_DELAY; i++) begin
                fire_pipe[i] <= fire_pipe[i-1];
                row_pipe[i]  <= row_pipe[i-1];
            end
        end
    end

`ifdef SPMM_SCHED_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else begin
            if (busy)    perf_cycles <= perf_cycles + 32'd1;
            if (lhs_acc) perf_jobs   <= perf_jobs + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_jobs   = '0;
`endif
endmodule

// File: doc/spmm_sched.md
# spmm_sched

Central sequencer for the SpMM tile engine. Owns the RHS-load, LHS-stream, PE-drain and output-dump phases, and drives all ready/handshake outputs at the SpMM boundary. Issues the write, issue and accumulate strobes that step the RHS buffer, PE array and output buffer. Supports normal, weight-stationary (ws), output-stationary (os) and combined (wos) jobs.

## Interface
Parameters:
- N, 16, tile dimension; power of two, ≥ 4.
- PE_DELAY, $clog2(N)+1, multiply-plus-adder-tree latency in cycles.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rhs_start  in  1  begin RHS load; this cycle carries beat 0.
- lhs_start  in  1  begin LHS job; this cycle carries row 0.
- lhs_ws  in  1  keep RHS after this job; sampled with lhs_start.
- lhs_os  in  1  accumulate into held output; sampled with lhs_start.
- out_start  in  1  begin output dump.
- rhs_ready  out  1  RHS load accepted this cycle.
- lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos  out  1 each  job of that mode accepted.
- out_ready  out  1  dump accepted.
- rhs_we  out  1  write strobe for RHS buffer.
- rhs_beat  out  $clog2(N/4)  RHS row group; columns 4·rhs_beat … 4·rhs_beat+3.
- lhs_fire  out  1  PE issue strobe.
- lhs_row  out  $clog2(N)  row being issued.
- acc_clear  out  1  clear output buffer; one pulse.
- acc_we  out  1  PE result valid; write or accumulate.
- acc_row  out  $clog2(N)  destination row for acc_we.
- out_rd_en  out  1  output-buffer read strobe.
- out_beat  out  $clog2(N/4)  output row group.
- busy  out  1  state ≠ IDLE and ≠ READY.
- err  out  1  sticky protocol-violation flag.
- perf_cycles, perf_jobs  out  32 each  performance counters; see Configuration.

## Operation
- States:
  - IDLE: no valid RHS.
  - RHS_LOAD
  - READY: RHS valid.
  - LHS_RUN
  - DRAIN
  - OUT_DUMP
- Internal flags:
  - acc_valid: output buffer holds an undumped result.
  - ret_state: state to return to after OUT_DUMP.
- Ready decode (combinational from registered state):
  - rhs_ready = IDLE.
  - lhs_ready_ns = lhs_ready_ws = READY & !acc_valid.
  - lhs_ready_os = lhs_ready_wos = READY & acc_valid.
  - out_ready = (IDLE | READY) & acc_valid.
- Start acceptance: a start is accepted only if its ready is high that cycle. For lhs_start, the ready is the one matching {lhs_ws, lhs_os}.
- Start with ready low: the start is ignored and err is set. err clears only on reset.
- Same-cycle conflicts: out_start has priority over rhs_start and lhs_start. The losing start is ignored and does not set err.
- RHS_LOAD:
  - rhs_we=1 on the accept cycle and the following N/4−1 cycles, with rhs_beat = 0, 1, ….
  - rhs_start is not re-sampled during the load.
  - After the last beat: go to READY.
- LHS_RUN:
  - lhs_fire=1 for N consecutive cycles starting at the accept cycle; lhs_row = 0 … N−1.
  - acc_clear=1 on the accept cycle iff lhs_os=0.
  - The ws and os bits are latched at accept.
- DRAIN: acc_we/acc_row are lhs_fire/lhs_row delayed by exactly PE_DELAY cycles (shift-register pipeline).
- End of DRAIN (last acc_we cycle):
  - acc_valid←1.
  - Next state is READY if the latched ws=1, otherwise IDLE.
- OUT_DUMP:
  - out_rd_en=1 for N/4 consecutive cycles starting at the accept cycle; out_beat = 0 ….
  - The last beat clears acc_valid and returns to ret_state.
- Counter widths wrap naturally. rhs_beat wraps N/4−1→0 only at load end.

## Timing
- Reset values:
  - state=IDLE, acc_valid=0, err=0.
  - rhs_ready=1.
  - All other outputs 0, including the perf counters.
- Reset asserted mid-operation aborts the phase immediately. No strobe is issued after assertion.
- Latencies from accept:
  - RHS load: N/4 cycles; lhs_ready_* can rise in the cycle after the last beat.
  - Job: the first acc_we is at accept+PE_DELAY; the last acc_we is at accept+N−1+PE_DELAY.
  - out_ready rises the cycle after the last acc_we.
  - Dump: N/4 cycles.
- Back-to-back jobs: a new lhs_start is accepted no earlier than the cycle after DRAIN ends. There is no overlap with acc_we.
- Readies are registered-state functions; there is no same-cycle combinational path from the start inputs to the ready outputs.

## Configuration
- SPMM_SCHED_PERF_EN defined:
  - perf_cycles counts cycles with busy=1.
  - perf_jobs counts accepted lhs_start.
  - Both are 32-bit, wrap, and reset to 0.
- Undefined: perf_cycles and perf_jobs are tied to 0 and no counter logic is instantiated.

## Test plan
All scenarios use N=16, PE_DELAY=5.
- Reset then RHS load: release reset, pulse rhs_start at cycle 0 -> rhs_we at cycles 0–3 with rhs_beat 0,1,2,3; lhs_ready_ns=1 at cycle 4.
- ns job: lhs_start at cycle t -> lhs_fire t..t+15, acc_clear only at t, acc_we t+5..t+20 with acc_row 0..15; out_ready=1 at t+21; state IDLE, so rhs_ready=1.
- ws then os job:
  - First job with ws=1 -> READY after drain.
  - out_ready=1 and lhs_ready_os=1; lhs_start with os=1 -> acc_clear stays 0.
  - Then out_start -> out_rd_en for 4 cycles, out_beat 0..3; afterwards acc_valid=0 and lhs_ready_ns=1.
- Conflict: in READY with acc_valid=1, assert lhs_start(os=1) and out_start in the same cycle -> dump runs, no lhs_fire, err stays 0.
- Violation: lhs_start in IDLE -> no lhs_fire, err=1 and held until reset.
- Reset mid-job: deassert-low reset at lhs_row=7 -> all strobes 0 in that cycle; after release, state=IDLE and perf counters are 0 (with SPMM_SCHED_PERF_EN).
